rr_stream_mux: RTL and testbench

- Parametrised successor to the team's 4:1 combinational selector: an N_CH-channel, WIDTH-bit stream multiplexer.
- Selects channels by round-robin arbitration instead of an external sel input.
- Per-channel valid/ready handshake and a registered output stage.
- Funnels several producer streams into one consumer, e.g. lab peripherals sharing one output bus.

---
 rtl/rr_stream_mux.sv | 133 +++++++++++++
 tb/tb_rr_stream_mux.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_stream_mux.sv
// ---------------------------------------------------------------------------
// rr_stream_mux
//
// Round-robin stream multiplexer. It merges N_CH valid/ready producer
// streams into a single registered output stream. The arbiter scans the
// channels starting at rr_ptr and grants the first valid one. The pointer
// then moves to the channel after the winner, so continuously valid
// channels are served in strict rotation.
//
// Parameters
//   N_CH   number of input channels (2..16)
//   WIDTH  data bits per channel
//   SEL_W  channel index width, derived from N_CH (do not override)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   per-channel data valid
//   in_data    channel i occupies bits [i*WIDTH +: WIDTH]
//   in_ready   per-channel accept, one-hot or zero
//   out_valid  registered output valid
//   out_data   registered output data
//   out_sel    index of the channel that produced out_data
//   out_ready  consumer accept
//   grant_cnt  (RR_STREAM_MUX_CNT_EN only) one 16-bit wrapping transfer
//              counter per channel, channel i at [i*16 +: 16]
//
// Build option
//   RR_STREAM_MUX_CNT_EN  define to add the per-channel grant counters and
//                         the grant_cnt port.
// ---------------------------------------------------------------------------
module rr_stream_mux #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  input  logic                  out_ready
`ifdef RR_STREAM_MUX_CNT_EN
  ,
  output logic [N_CH*16-1:0]    grant_cnt
`endif
);

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] grant;
  logic [SEL_W-1:0] rr_next;
  logic             any_valid;
  logic             load_en;
  logic             transfer;

  // The output register can take a new word when it is empty or when the
  // word it holds is being consumed on this same edge.
  assign load_en = !out_valid || out_ready;

  // Search order is rr_ptr, rr_ptr+1, ..., wrapping modulo N_CH. The loop
  // runs from the farthest offset down to offset 0, so the valid channel
  // closest to rr_ptr writes grant last and wins.
  // NOTE: every output of this block is given a default value before the
  // loop, so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    logic [SEL_W:0] idx;
    any_valid = 1'b0;
    grant     = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + (SEL_W + 1)'(k);
      if (idx >= (SEL_W + 1)'(N_CH)) begin
        idx = idx - (SEL_W + 1)'(N_CH);
      end
      if (in_valid[idx[SEL_W-1:0]]) begin
        any_valid = 1'b1;
        grant     = idx[SEL_W-1:0];
      end
    end
  end

  // The reset term keeps in_ready at zero for as long as reset is held.
  assign transfer = any_valid && load_en && !reset;
  assign in_ready = transfer ? (N_CH'(1) << grant) : '0;

  // The pointer moves to the channel after the winner. N_CH need not be a
  // power of two, so the wrap is explicit.
  assign rr_next = (grant == SEL_W'(N_CH - 1)) ? '0 : grant + SEL_W'(1);

  // NOTE: registers are updated with non-blocking assignments. Every
  // always_ff block then samples values from before the edge, whatever
  // order the simulator runs the blocks in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      rr_ptr    <= '0;
    end else if (transfer) begin
      // A load covers the consume-and-load case: out_valid stays 1.
      out_valid <= 1'b1;
      out_data  <= in_data[grant*WIDTH +: WIDTH];
      out_sel   <= grant;
      rr_ptr    <= rr_next;
    end else if (out_ready) begin
      // Output drained with nothing new to load. Data and index hold.
      out_valid <= 1'b0;
    end
  end

`ifdef RR_STREAM_MUX_CNT_EN
  logic [15:0] cnt_q [N_CH];

  // NOTE: this array is a small set of flip-flops, not a RAM macro, so
  // resetting it is cheap and it is required to clear the counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (transfer) begin
      cnt_q[grant] <= cnt_q[grant] + 16'd1;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_cnt_out
    assign grant_cnt[i*16 +: 16] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_rr_stream_mux.sv
// ---------------------------------------------------------------------------
// tb_rr_stream_mux
//
// Directed bench for rr_stream_mux with N_CH=4 and WIDTH=8. Inputs change
// 1 time unit after a rising edge. Registered outputs are sampled at that
// same point. in_ready is sampled 1 time unit after each input change.
// Expected values are worked out by hand from the arbitration rules.
// ---------------------------------------------------------------------------
module tb_rr_stream_mux;

  localparam int N_CH  = 4;
  localparam int WIDTH = 8;
  localparam int SEL_W = $clog2(N_CH);

  logic                  clk;
  logic                  reset;
  logic [N_CH-1:0]       in_valid;
  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_sel;
  logic                  out_ready;
`ifdef RR_STREAM_MUX_CNT_EN
  logic [N_CH*16-1:0]    grant_cnt;
`endif

  int checks = 0;
  int errors = 0;

  rr_stream_mux #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
`ifdef RR_STREAM_MUX_CNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Watchdog so the bench always ends on its own.
  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] rr_exp_data [6] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10, 8'h11};
  logic [1:0] rr_exp_sel  [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  initial begin
    reset     = 1'b1;
    in_valid  = '0;
    in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
    out_ready = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_out_sel",   64'(out_sel),   64'd0);
    in_valid = 4'b1111;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    in_valid = '0;
    tick();
    tick();
    reset = 1'b0;

    // Single channel: only ch2 valid, streaming at one word per cycle.
    in_data[2*WIDTH +: WIDTH] = 8'hA5;
    in_valid  = 4'b0100;
    out_ready = 1'b1;
    #1;
    check("single_in_ready", 64'(in_ready), 64'h4);
    tick();
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_data",  64'(out_data),  64'hA5);
    check("single_sel",   64'(out_sel),   64'd2);
    in_data[2*WIDTH +: WIDTH] = 8'h5A;
    #1;
    check("single_in_ready2", 64'(in_ready), 64'h4);
    tick();
    check("stream_valid", 64'(out_valid), 64'd1);
    check("stream_data",  64'(out_data),  64'h5A);

    // Reset asserted between edges while out_valid=1: outputs clear at once.
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_data",  64'(out_data),  64'd0);
    check("async_rst_sel",   64'(out_sel),   64'd0);
    check("async_rst_ready", 64'(in_ready),  64'd0);
    tick();
    reset    = 1'b0;
    in_valid = '0;

    // Output consumed with no new transfer: valid drops, data holds.
    in_valid = 4'b0010;
    tick();
    in_valid = '0;
    tick();
    check("drain_valid", 64'(out_valid), 64'd0);
    check("drain_data",  64'(out_data),  64'h11);
    check("drain_sel",   64'(out_sel),   64'd1);

    // Return the pointer to 0 for the rotation test.
    reset = 1'b1;
    #1;
    reset = 1'b0;

    // Round-robin: all four channels valid.
    in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    in_valid = 4'b1111;
    #1;
    check("rr_first_ready", 64'(in_ready), 64'h1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("rr_sel_%0d", i),  64'(out_sel),  64'(rr_exp_sel[i]));
      check($sformatf("rr_data_%0d", i), 64'(out_data), 64'(rr_exp_data[i]));
    end
`ifdef RR_STREAM_MUX_CNT_EN
    check("cnt_after_rr", 64'(grant_cnt), {16'd1, 16'd1, 16'd2, 16'd2});
`endif

    // Backpressure: hold the sel=1 / 8'h11 word for 3 cycles.
    out_ready = 1'b0;
    #1;
    check("bp_in_ready0", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("bp_in_ready_%0d", i), 64'(in_ready),  64'd0);
      check($sformatf("bp_valid_%0d", i),    64'(out_valid), 64'd1);
      check($sformatf("bp_data_%0d", i),     64'(out_data),  64'h11);
      check($sformatf("bp_sel_%0d", i),      64'(out_sel),   64'd1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(in_ready), 64'h4);
    tick();
    check("bp_release_sel",  64'(out_sel),  64'd2);
    check("bp_release_data", 64'(out_data), 64'h12);

    // Wrap and skip: rr_ptr=3, only ch3 and ch0 valid.
    in_valid = 4'b1001;
    #1;
    check("wrap_ready_ch3", 64'(in_ready), 64'h8);
    tick();
    check("wrap_sel_ch3", 64'(out_sel),  64'd3);
    check("wrap_data_ch3", 64'(out_data), 64'h13);
    check("wrap_ready_ch0", 64'(in_ready), 64'h1);
    tick();
    check("wrap_sel_ch0", 64'(out_sel), 64'd0);
    // rr_ptr is now 1. The search must wrap from 1 to reach ch0.
    in_valid = 4'b0001;
    #1;
    check("wrap_search_ready", 64'(in_ready), 64'h1);
    tick();
    check("wrap_search_sel",   64'(out_sel),   64'd0);
    check("wrap_search_valid", 64'(out_valid), 64'd1);

    // Final reset clears everything, including the counters.
    in_valid = '0;
    #2;
    reset = 1'b1;
    #1;
    check("final_rst_valid", 64'(out_valid), 64'd0);
`ifdef RR_STREAM_MUX_CNT_EN
    check("final_rst_cnt", 64'(grant_cnt), 64'd0);
`endif
    tick();
    reset = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
